ahb_reg_bridge: RTL and testbench

// AHB-Lite slave front end that initiates accesses on the simple register-file port (rd_en/wr_en/address/wr_data -> rd_data/ready/error).

---
 rtl/ahb_pkg.sv | 25 ++
 rtl/ahb_reg_bridge_if.sv | 41 ++++
 rtl/wait_timeout_ctr.sv | 31 +++
 rtl/ahb_reg_bridge.sv | 120 ++++++++++++
 tb/tb_ahb_reg_bridge.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and bridge FSM state codes used by the register-file bridge.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  localparam logic       HRESP_OKAY  = 1'b0;
  localparam logic       HRESP_ERROR = 1'b1;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;

  typedef logic [1:0] bridge_state_t;
  localparam bridge_state_t ST_IDLE   = 2'd0;
  localparam bridge_state_t ST_ACCESS = 2'd1;
  localparam bridge_state_t ST_ERR1   = 2'd2;
  localparam bridge_state_t ST_ERR2   = 2'd3;

  function automatic logic is_active_trans(input logic [1:0] trans);
    return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_reg_bridge_if.sv
// AHB-Lite slave bus plus register-file peripheral port bundled for one bridge instance.
interface ahb_reg_bridge_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  import ahb_pkg::*;

  logic                  hsel;
  logic [ADDR_WIDTH-1:0] haddr;
  logic                  hwrite;
  logic [1:0]            htrans;
  logic [2:0]            hsize;
  logic [DATA_WIDTH-1:0] hwdata;
  logic                  hready;
  logic [DATA_WIDTH-1:0] hrdata;
  logic                  hreadyout;
  logic                  hresp;

  logic                  rd_en;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  ready;
  logic                  error;

  modport slave (
    input  hsel, haddr, hwrite, htrans, hsize, hwdata, hready,
    input  rd_data, ready, error,
    output hrdata, hreadyout, hresp,
    output rd_en, wr_en, address, wr_data
  );

  modport master (
    output hsel, haddr, hwrite, htrans, hsize, hwdata, hready,
    output rd_data, ready, error,
    input  hrdata, hreadyout, hresp,
    input  rd_en, wr_en, address, wr_data
  );

endinterface

// File: rtl/wait_timeout_ctr.sv
// Counts consecutive peripheral wait cycles; o_expired marks the cycle on which the
// count reaches TIMEOUT_CYCLES (never asserted when TIMEOUT_CYCLES is 0).
module wait_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + CW'(1);
    end
  end

  // Expiry is flagged on the wait cycle that would make the count equal TIMEOUT_CYCLES.
  assign o_expired = (TIMEOUT_CYCLES != 0) && i_enable && (r_count == LAST);

endmodule

// File: rtl/ahb_reg_bridge.sv
// AHB-Lite slave to register-file bridge with wait states and two-cycle ERROR responses.
// Optional word-range check enabled by defining REG_BRIDGE_RANGE_CHK_EN.
module ahb_reg_bridge
  import ahb_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_FILE_DEPTH = 16,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rst,
  ahb_reg_bridge_if.slave bus
);

`ifdef REG_BRIDGE_RANGE_CHK_EN
  localparam logic RANGE_CHK = 1'b1;
`else
  localparam logic RANGE_CHK = 1'b0;
`endif

  bridge_state_t         r_state;
  bridge_state_t         w_state_next;
  bridge_state_t         w_accept_state;
  logic                  r_write;
  logic [ADDR_WIDTH-1:0] r_addr;

  logic w_ok_done;
  logic w_can_accept;
  logic w_accept;
  logic w_illegal;
  logic w_out_of_range;
  logic w_wait;
  logic w_expired;
  logic w_hreadyout;
  logic w_hresp;
  logic w_rd_en;
  logic w_wr_en;

  assign w_ok_done      = (r_state == ST_ACCESS) && bus.ready && !bus.error;
  // A new address phase is only taken when the previous data phase is finishing.
  assign w_can_accept   = (r_state == ST_IDLE) || (r_state == ST_ERR2) || w_ok_done;
  assign w_accept       = w_can_accept && bus.hsel && bus.hready && is_active_trans(bus.htrans);
  assign w_out_of_range = ({2'b00, bus.haddr[ADDR_WIDTH-1:2]} >= ADDR_WIDTH'(REG_FILE_DEPTH));
  assign w_illegal      = (bus.hsize != HSIZE_WORD) || (bus.haddr[1:0] != 2'b00)
                          || (RANGE_CHK && w_out_of_range);
  assign w_accept_state = w_illegal ? ST_ERR1 : ST_ACCESS;
  assign w_wait         = (r_state == ST_ACCESS) && !bus.ready;

  wait_timeout_ctr #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_wait_ctr (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_accept || bus.ready),
    .i_enable  (w_wait),
    .o_expired (w_expired)
  );

  always_comb begin
    w_state_next = r_state;
    w_hreadyout  = 1'b1;
    w_hresp      = HRESP_OKAY;
    w_rd_en      = 1'b0;
    w_wr_en      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_next = w_accept_state;
      end
      ST_ACCESS: begin
        w_rd_en = ~r_write;
        w_wr_en = r_write;
        if (bus.ready) begin
          if (bus.error) begin
            w_hreadyout  = 1'b0;
            w_hresp      = HRESP_ERROR;
            w_state_next = ST_ERR2;
          end else begin
            w_state_next = w_accept ? w_accept_state : ST_IDLE;
          end
        end else begin
          w_hreadyout = 1'b0;
          if (w_expired) w_state_next = ST_ERR1;
        end
      end
      ST_ERR1: begin
        w_hreadyout  = 1'b0;
        w_hresp      = HRESP_ERROR;
        w_state_next = ST_ERR2;
      end
      default: begin
        w_hresp      = HRESP_ERROR;
        w_state_next = w_accept ? w_accept_state : ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_write <= 1'b0;
      r_addr  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_write <= bus.hwrite;
        r_addr  <= {2'b00, bus.haddr[ADDR_WIDTH-1:2]};
      end
    end
  end

  assign bus.hreadyout = w_hreadyout;
  assign bus.hresp     = w_hresp;
  assign bus.rd_en     = w_rd_en;
  assign bus.wr_en     = w_wr_en;
  assign bus.address   = r_addr;
  assign bus.wr_data   = bus.hwdata;
  assign bus.hrdata    = (w_ok_done && !r_write) ? bus.rd_data : {DATA_WIDTH{1'b0}};

endmodule

// File: tb/tb_ahb_reg_bridge.sv
// Directed bench for ahb_reg_bridge: single-slave bus (hready = hreadyout) and a 16-word register model.
module tb_ahb_reg_bridge;
  import ahb_pkg::*;

  logic        clk;
  logic        rst_n;
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] mem [16];
  logic [3:0]  flags;

  ahb_reg_bridge_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  ahb_reg_bridge #(
    .DATA_WIDTH     (32),
    .ADDR_WIDTH     (32),
    .REG_FILE_DEPTH (16),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus.slave)
  );

  assign bus.hready  = bus.hreadyout;
  assign bus.rd_data = mem[bus.address[3:0]];
  assign flags       = {bus.hreadyout, bus.hresp, bus.rd_en, bus.wr_en};

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h1000_0000 + i;
    end else if (bus.wr_en && bus.ready && !bus.error) begin
      mem[bus.address[3:0]] <= bus.wr_data;
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want finish");
    $fatal(1);
  end

  task automatic addr_phase(input logic sel, input logic [31:0] addr, input logic wr,
                            input logic [1:0] trans, input logic [2:0] size);
    bus.hsel   = sel;
    bus.haddr  = addr;
    bus.hwrite = wr;
    bus.htrans = trans;
    bus.hsize  = size;
  endtask

  task automatic bus_idle();
    addr_phase(1'b0, 32'h0, 1'b0, HTRANS_IDLE, HSIZE_WORD);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus_idle();
    bus.hwdata = '0;
    bus.ready  = 1'b1;
    bus.error  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (flags !== 4'b1000) begin n_err++; $display("FAIL reset_flags: got %b want 1000", flags); end
    n_vec++; if (bus.address !== 32'h0) begin n_err++; $display("FAIL reset_address: got %h want 0", bus.address); end
    n_vec++; if (bus.hrdata !== 32'h0) begin n_err++; $display("FAIL reset_hrdata: got %h want 0", bus.hrdata); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    $display("reset released");
  endtask

  task automatic test_idle_busy();
    addr_phase(1'b1, 32'h8, 1'b0, HTRANS_BUSY, HSIZE_WORD);
    @(posedge clk); #1;
    addr_phase(1'b1, 32'h8, 1'b0, HTRANS_IDLE, HSIZE_WORD);
    @(negedge clk);
    n_vec++; if (flags !== 4'b1000) begin n_err++; $display("FAIL busy_not_accepted: got %b want 1000", flags); end
    @(posedge clk); #1;
    @(negedge clk);
    n_vec++; if (flags !== 4'b1000) begin n_err++; $display("FAIL idle_not_accepted: got %b want 1000", flags); end
    bus_idle();
    @(posedge clk); #1;
    $display("busy/idle transfers ignored");
  endtask

  task automatic test_write();
    addr_phase(1'b1, 32'h8, 1'b1, HTRANS_NONSEQ, HSIZE_WORD);
    @(posedge clk); #1;
    bus_idle();
    bus.hwdata = 32'hDEAD_BEEF;
    @(negedge clk);
    n_vec++; if (flags !== 4'b1001) begin n_err++; $display("FAIL write_flags: got %b want 1001", flags); end
    n_vec++; if (bus.address !== 32'h2) begin n_err++; $display("FAIL write_address: got %h want 2", bus.address); end
    n_vec++; if (bus.wr_data !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL write_data: got %h want deadbeef", bus.wr_data); end
    n_vec++; if (bus.hrdata !== 32'h0) begin n_err++; $display("FAIL write_hrdata: got %h want 0", bus.hrdata); end
    @(posedge clk); #1;
    @(negedge clk);
    n_vec++; if (flags !== 4'b1000) begin n_err++; $display("FAIL write_strobe_drop: got %b want 1000", flags); end
    @(posedge clk); #1;
    $display("write 0x08 = deadbeef");
  endtask

  task automatic test_back_to_back();
    addr_phase(1'b1, 32'h8, 1'b0, HTRANS_NONSEQ, HSIZE_WORD);
    @(posedge clk); #1;
    addr_phase(1'b1, 32'hC, 1'b0, HTRANS_SEQ, HSIZE_WORD);
    @(negedge clk);
    n_vec++; if (flags !== 4'b1010) begin n_err++; $display("FAIL b2b_first_flags: got %b want 1010", flags); end
    n_vec++; if (bus.hrdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL b2b_first_data: got %h want deadbeef", bus.hrdata); end
    @(posedge clk); #1;
    bus_idle();
    @(negedge clk);
    n_vec++; if (flags !== 4'b1010) begin n_err++; $display("FAIL b2b_second_flags: got %b want 1010", flags); end
    n_vec++; if (bus.address !== 32'h3) begin n_err++; $display("FAIL b2b_second_address: got %h want 3", bus.address); end
    n_vec++; if (bus.hrdata !== 32'h1000_0003) begin n_err++; $display("FAIL b2b_second_data: got %h want 10000003", bus.hrdata); end
    @(posedge clk); #1;
    @(negedge clk);
    n_vec++; if (bus.hrdata !== 32'h0) begin n_err++; $display("FAIL b2b_idle_hrdata: got %h want 0", bus.hrdata); end
    @(posedge clk); #1;
    $display("back-to-back reads 0x08, 0x0C");
  endtask

  task automatic test_wait_states();
    addr_phase(1'b1, 32'h14, 1'b0, HTRANS_NONSEQ, HSIZE_WORD);
    bus.ready = 1'b0;
    @(posedge clk); #1;
    bus_idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++; if (flags !== 4'b0010) begin n_err++; $display("FAIL wait_flags[%0d]: got %b want 0010", i, flags); end
      n_vec++; if (bus.address !== 32'h5) begin n_err++; $display("FAIL wait_address[%0d]: got %h want 5", i, bus.address); end
      @(posedge clk); #1;
    end
    bus.ready = 1'b1;
    @(negedge clk);
    n_vec++; if (flags !== 4'b1010) begin n_err++; $display("FAIL wait_done_flags: got %b want 1010", flags); end
    n_vec++; if (bus.hrdata !== 32'h1000_0005) begin n_err++; $display("FAIL wait_done_data: got %h want 10000005", bus.hrdata); end
    @(posedge clk); #1;
    $display("read 0x14 with 3 wait states");
  endtask

  task automatic test_illegal();
    logic [31:0] addrs [2];
    logic [2:0]  sizes [2];
    addrs[0] = 32'h8; sizes[0] = 3'b000;
    addrs[1] = 32'h2; sizes[1] = HSIZE_WORD;
    for (int v = 0; v < 2; v++) begin
      addr_phase(1'b1, addrs[v], v[0], HTRANS_NONSEQ, sizes[v]);
      @(posedge clk); #1;
      bus_idle();
      @(negedge clk);
      n_vec++; if (flags !== 4'b0100) begin n_err++; $display("FAIL illegal%0d_err1: got %b want 0100", v, flags); end
      @(posedge clk); #1;
      @(negedge clk);
      n_vec++; if (flags !== 4'b1100) begin n_err++; $display("FAIL illegal%0d_err2: got %b want 1100", v, flags); end
      @(posedge clk); #1;
      @(negedge clk);
      n_vec++; if (flags !== 4'b1000) begin n_err++; $display("FAIL illegal%0d_idle: got %b want 1000", v, flags); end
      @(posedge clk); #1;
      $display("illegal access %0d (haddr=%h hsize=%b) errored", v, addrs[v], sizes[v]);
    end
  endtask

  task automatic test_periph_error();
    addr_phase(1'b1, 32'h4, 1'b1, HTRANS_NONSEQ, HSIZE_WORD);
    @(posedge clk); #1;
    bus_idle();
    bus.hwdata = 32'hBAD0_BAD0;
    bus.error  = 1'b1;
    @(negedge clk);
    n_vec++; if (flags !== 4'b0101) begin n_err++; $display("FAIL perr_first: got %b want 0101", flags); end
    @(posedge clk); #1;
    bus.error = 1'b0;
    @(negedge clk);
    n_vec++; if (flags !== 4'b1100) begin n_err++; $display("FAIL perr_second: got %b want 1100", flags); end
    @(posedge clk); #1;
    $display("peripheral error on write 0x04");
  endtask

  task automatic test_timeout();
    addr_phase(1'b1, 32'h10, 1'b0, HTRANS_NONSEQ, HSIZE_WORD);
    bus.ready = 1'b0;
    @(posedge clk); #1;
    bus_idle();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_vec++; if (flags !== 4'b0010) begin n_err++; $display("FAIL timeout_wait[%0d]: got %b want 0010", i, flags); end
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_vec++; if (flags !== 4'b0100) begin n_err++; $display("FAIL timeout_err1: got %b want 0100", flags); end
    @(posedge clk); #1;
    @(negedge clk);
    n_vec++; if (flags !== 4'b1100) begin n_err++; $display("FAIL timeout_err2: got %b want 1100", flags); end
    bus.ready = 1'b1;
    @(posedge clk); #1;
    $display("read 0x10 timed out after 4 waits");
  endtask

  task automatic test_range();
    addr_phase(1'b1, 32'h40, 1'b0, HTRANS_NONSEQ, HSIZE_WORD);
    @(posedge clk); #1;
    bus_idle();
    @(negedge clk);
`ifdef REG_BRIDGE_RANGE_CHK_EN
    n_vec++; if (flags !== 4'b0100) begin n_err++; $display("FAIL range_err1: got %b want 0100", flags); end
    @(posedge clk); #1;
    @(negedge clk);
    n_vec++; if (flags !== 4'b1100) begin n_err++; $display("FAIL range_err2: got %b want 1100", flags); end
`else
    n_vec++; if (flags !== 4'b1010) begin n_err++; $display("FAIL range_fwd_flags: got %b want 1010", flags); end
    n_vec++; if (bus.address !== 32'h10) begin n_err++; $display("FAIL range_fwd_address: got %h want 10", bus.address); end
    n_vec++; if (bus.hrdata !== 32'h1000_0000) begin n_err++; $display("FAIL range_fwd_data: got %h want 10000000", bus.hrdata); end
`endif
    @(posedge clk); #1;
    $display("read 0x40 (word 16)");
  endtask

  task automatic test_reset_mid();
    addr_phase(1'b1, 32'h14, 1'b0, HTRANS_NONSEQ, HSIZE_WORD);
    bus.ready = 1'b0;
    @(posedge clk); #1;
    bus_idle();
    @(negedge clk);
    n_vec++; if (flags !== 4'b0010) begin n_err++; $display("FAIL midrst_pre: got %b want 0010", flags); end
    #1 rst_n = 1'b0;
    #1;
    n_vec++; if (flags !== 4'b1000) begin n_err++; $display("FAIL midrst_flags: got %b want 1000", flags); end
    n_vec++; if (bus.address !== 32'h0) begin n_err++; $display("FAIL midrst_address: got %h want 0", bus.address); end
    @(posedge clk); #1;
    rst_n     = 1'b1;
    bus.ready = 1'b1;
    addr_phase(1'b1, 32'hC, 1'b1, HTRANS_NONSEQ, HSIZE_WORD);
    @(posedge clk); #1;
    addr_phase(1'b1, 32'hC, 1'b0, HTRANS_NONSEQ, HSIZE_WORD);
    bus.hwdata = 32'h1234_5678;
    @(negedge clk);
    n_vec++; if (flags !== 4'b1001) begin n_err++; $display("FAIL postrst_write: got %b want 1001", flags); end
    n_vec++; if (bus.address !== 32'h3) begin n_err++; $display("FAIL postrst_address: got %h want 3", bus.address); end
    @(posedge clk); #1;
    bus_idle();
    @(negedge clk);
    n_vec++; if (bus.hrdata !== 32'h1234_5678) begin n_err++; $display("FAIL postrst_read: got %h want 12345678", bus.hrdata); end
    @(posedge clk); #1;
    $display("reset during wait, then write/read 0x0C");
  endtask

  initial begin
    test_reset();
    test_idle_busy();
    test_write();
    test_back_to_back();
    test_wait_states();
    test_illegal();
    test_periph_error();
    test_timeout();
    test_range();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
